// File: rtl/vlu_pkg.sv
// Shared types and constants for the vector load unit.
package vlu_pkg;

  // Control FSM states; exported on the debug state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vlu_state_t;

  // Deepest memory read latency the tag pipeline is built for.
  localparam int MAX_MEM_LAT = 4;

  // Width of an element count able to hold 0..vlen.
  function automatic int vlu_len_w(input int vlen);
    return $clog2(vlen + 1);
  endfunction

endpackage

// File: rtl/vlu_tag_pipe.sv
// Tag pipeline for the vector load unit: carries {valid, element index}
// alongside each in-flight read so the returning data lands in the right
// vector slot. LAT=0 is a combinational pass-through.
module vlu_tag_pipe #(
  parameter int LAT   = 0,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid_i,
  input  logic [IDX_W-1:0] push_idx_i,
  output logic             pop_valid_o,
  output logic [IDX_W-1:0] pop_idx_o,
  output logic             empty_o
);

  if (LAT == 0) begin : g_bypass
    // Combinational memory: the tag emerges in the cycle it is issued.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign pop_valid_o    = push_valid_i;
    assign pop_idx_o      = push_idx_i;
    assign empty_o        = 1'b1;
  end else begin : g_pipe
    logic [LAT-1:0]            valid_q;
    logic [LAT-1:0][IDX_W-1:0] idx_q;

    // Shift tags one stage per cycle; reset clears every stage.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= '0;
        idx_q   <= '0;
      end else begin
        valid_q[0] <= push_valid_i;
        idx_q[0]   <= push_idx_i;
        for (int s = 1; s < LAT; s++) begin
          valid_q[s] <= valid_q[s-1];
          idx_q[s]   <= idx_q[s-1];
        end
      end
    end

    assign pop_valid_o = valid_q[LAT-1];
    assign pop_idx_o   = idx_q[LAT-1];

    // Empty means nothing remains behind the tag now leaving the last stage,
    // so the pipe is fully drained once this cycle's capture completes.
    always_comb begin
      empty_o = 1'b1;
      for (int s = 0; s < LAT - 1; s++) begin
        if (valid_q[s]) empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vector_load_unit.sv
// Vector load unit: issues len strided reads (len clamped to VLEN), collects
// the returning data into a vector image and pulses done when complete.
// Optional build macro VLU_ADDR_BOUND_CHECK_EN: stop issuing when the address
// accumulator carries out, drain in-flight reads and report error.
// Handshake: start is sampled only in IDLE; busy is high while reads are
// issued or in flight; done is a single-cycle pulse with busy low.
module vector_load_unit
  import vlu_pkg::*;
#(
  parameter int VLEN    = 20,
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_address,
  input  logic [ADDR_W-1:0]             stride,
  input  logic [vlu_len_w(VLEN)-1:0]    length,
  input  logic [DATA_W-1:0]             read_data,
  output logic [ADDR_W-1:0]             read_address,
  output logic                          read_en,
  output logic [DATA_W-1:0]             scalar_data,
  output logic [VLEN-1:0][DATA_W-1:0]   vector_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output vlu_state_t                    dbg_state_o
);

  localparam int LEN_W = vlu_len_w(VLEN);
  localparam int LAT   = (MEM_LAT > MAX_MEM_LAT) ? MAX_MEM_LAT : MEM_LAT;

  vlu_state_t                state_q, state_d;
  logic [ADDR_W-1:0]         acc_q, acc_d;
  logic [ADDR_W-1:0]         stride_q;
  logic [LEN_W-1:0]          len_q, idx_q, idx_d;
  logic [VLEN-1:0][DATA_W-1:0] vec_q;
  logic [LEN_W-1:0]          len_clamped;
  logic                      accept;
  logic                      push_valid, pop_valid, pipe_empty;
  logic [LEN_W-1:0]          pop_idx;

`ifdef VLU_ADDR_BOUND_CHECK_EN
  logic              ovf_q, ovf_d, err_q, err_d;
  logic [ADDR_W:0]   acc_sum;
  assign acc_sum = {1'b0, acc_q} + {1'b0, stride_q};
`endif

  assign len_clamped = (length > LEN_W'(VLEN)) ? LEN_W'(VLEN) : length;

  // Next-state, address issue and tag push.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    accept       = 1'b0;
    read_en      = 1'b0;
    read_address = '0;
    push_valid   = 1'b0;
`ifdef VLU_ADDR_BOUND_CHECK_EN
    ovf_d        = ovf_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          acc_d   = base_address;
          idx_d   = '0;
          state_d = (len_clamped == '0) ? DONE : ISSUE;
`ifdef VLU_ADDR_BOUND_CHECK_EN
          ovf_d   = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
`ifdef VLU_ADDR_BOUND_CHECK_EN
        // ovf_q marks that the current element's true address passed the top.
        if (ovf_q) begin
          err_d   = 1'b1;
          state_d = (LAT == 0) ? DONE : DRAIN;
        end else begin
          read_en      = 1'b1;
          read_address = acc_q;
          push_valid   = 1'b1;
          acc_d        = acc_sum[ADDR_W-1:0];
          ovf_d        = acc_sum[ADDR_W];
          idx_d        = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) state_d = (LAT == 0) ? DONE : DRAIN;
        end
`else
        read_en      = 1'b1;
        read_address = acc_q;
        push_valid   = 1'b1;
        acc_d        = acc_q + stride_q;
        idx_d        = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) state_d = (LAT == 0) ? DONE : DRAIN;
`endif
      end
      DRAIN: begin
        if (pipe_empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      stride_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      if (accept) begin
        stride_q <= stride;
        len_q    <= len_clamped;
      end
    end
  end

`ifdef VLU_ADDR_BOUND_CHECK_EN
  // Overflow tracking and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  vlu_tag_pipe #(
    .LAT   (LAT),
    .IDX_W (LEN_W)
  ) u_tag_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (push_valid),
    .push_idx_i   (idx_q),
    .pop_valid_o  (pop_valid),
    .pop_idx_o    (pop_idx),
    .empty_o      (pipe_empty)
  );

  // Vector image: cleared on an accepted start, filled as tags emerge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_q <= '0;
    end else if (accept) begin
      vec_q <= '0;
    end else if (pop_valid) begin
      vec_q[pop_idx] <= read_data;
    end
  end

  assign vector_data = vec_q;
  assign scalar_data = vec_q[0];
  assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule
